// File: rtl/otter_icache.sv
// Direct-mapped read-only instruction cache in front of BRAM port 1.
// Hits answer combinationally; a miss burst-fills one line in LINE_WORDS+2 cycles.
module otter_icache #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] PC,
  input  logic        PC_VALID,
  input  logic        FLUSH,
  output logic [31:0] IR,
  output logic        READY,
  output logic        STALL,
  output logic        MEM_RDEN1,
  output logic [13:0] MEM_ADDR1,
  input  logic [31:0] MEM_DOUT1
);

  localparam int OFS_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 14 - OFS_W - IDX_W;
  localparam logic [OFS_W-1:0] LAST_OFS = OFS_W'(LINE_WORDS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]       state;
  logic [13:0]      word;
  logic [OFS_W-1:0] ofs;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tags [NUM_LINES];
  logic [31:0]          data [NUM_LINES*LINE_WORDS];

  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic [OFS_W-1:0] ic;
  logic [OFS_W-1:0] cc;
  logic             cap_v;
  logic             flush_pend;
  logic [13:0]      last_addr;
  logic             hit;
  logic             unused_pc;

  assign word = PC[15:2];
  assign ofs  = word[OFS_W-1:0];
  assign idx  = word[OFS_W+IDX_W-1:OFS_W];
  assign tag  = word[13:OFS_W+IDX_W];
  assign unused_pc = ^{PC[31:16], PC[1:0]};

  assign hit   = (state == S_IDLE) && PC_VALID && valid[idx] && (tags[idx] == tag);
  assign READY = hit;
  assign IR    = hit ? data[{idx, ofs}] : 32'd0;
  assign STALL = PC_VALID && !hit;

  // The fill base is just the latched tag and index with a zero offset.
  assign MEM_RDEN1 = (state == S_FILL);
  assign MEM_ADDR1 = MEM_RDEN1 ? {fill_tag, fill_idx, ic} : last_addr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      valid      <= '0;
      ic         <= '0;
      cc         <= '0;
      cap_v      <= 1'b0;
      flush_pend <= 1'b0;
      last_addr  <= '0;
      fill_idx   <= '0;
      fill_tag   <= '0;
    end else begin
      cap_v <= MEM_RDEN1;
      if (cap_v) cc <= cc + 1'b1;
      if (MEM_RDEN1) last_addr <= MEM_ADDR1;

      case (state)
        S_IDLE: begin
          if (PC_VALID && !hit && !FLUSH) begin
            fill_idx <= idx;
            fill_tag <= tag;
            ic       <= '0;
            state    <= S_FILL;
          end
        end
        S_FILL: begin
          ic <= ic + 1'b1;
          if (ic == LAST_OFS) state <= S_DRAIN;
          if (FLUSH) flush_pend <= 1'b1;
        end
        S_DRAIN: begin
          flush_pend <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // A flush landing in DRAIN must also keep the finishing line invalid.
      if (FLUSH) begin
        valid <= '0;
      end else if (state == S_DRAIN && !flush_pend) begin
        valid[fill_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && state == S_DRAIN) tags[fill_idx] <= fill_tag;
    if (!RST && cap_v) data[{fill_idx, cc}] <= MEM_DOUT1;
  end

endmodule

// File: doc/otter_icache.md
# otter_icache

Direct-mapped, read-only instruction cache between the OTTER fetch stage and instruction port 1 (ADDR1/RDEN1/DOUT1) of the 64 KiB synchronous BRAM memory. Hits return the instruction combinationally in the same cycle. A miss stalls fetch while an FSM burst-fills one line from memory using one-cycle-latency synchronous word reads. A flush input invalidates the whole cache for self-modifying code or new program loads.

## Interface
- LINE_WORDS, 4, words per line; power of 2, at least 2
- NUM_LINES, 16, number of lines; power of 2
- Derived widths:
  - OFS_W = log2(LINE_WORDS)
  - IDX_W = log2(NUM_LINES)
  - TAG_W = 14 − OFS_W − IDX_W (8 at defaults)

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  synchronous, active-high reset
- PC  in  32  fetch byte address; only PC[15:2] is used, PC[1:0] and PC[31:16] are ignored
- PC_VALID  in  1  fetch request this cycle
- FLUSH  in  1  invalidate all lines
- IR  out  32  instruction; equals 0 when READY=0
- READY  out  1  IR is valid for the current PC
- STALL  out  1  equals PC_VALID & ~READY
- MEM_RDEN1  out  1  memory port-1 read enable
- MEM_ADDR1  out  14  memory port-1 word address
- MEM_DOUT1  in  32  memory port-1 data, valid the cycle after MEM_RDEN1

## Operation
- **Address split** of word address W = PC[15:2]:
  - offset = W[OFS_W−1:0]
  - index = W[OFS_W+IDX_W−1:OFS_W]
  - tag = W[13:OFS_W+IDX_W]
- **Storage:** per line, one valid bit, a TAG_W tag, and LINE_WORDS × 32 data. Valid bits and tags are flops. The data array may be flops or distributed RAM with a combinational read.
- **Hit:** state=IDLE & PC_VALID & valid[index] & tag match. Then READY=1 and IR=data[index][offset]. There is no memory access.
- **States:** IDLE, FILL, DRAIN.
- **IDLE:**
  - On PC_VALID & miss & ~FLUSH: latch fill_idx, fill_tag and base word address {W[13:OFS_W], OFS_W'0}; clear issue counter ic; go to FILL.
  - FLUSH has priority over starting a fill.
- **FILL:**
  - MEM_RDEN1=1, MEM_ADDR1 = base + ic; ic increments each cycle.
  - When ic = LINE_WORDS−1, go to DRAIN.
- **Capture:** a registered copy of MEM_RDEN1 (cap_v) and a capture counter cc. When cap_v=1, write MEM_DOUT1 into data[fill_idx][cc] and increment cc.
- **DRAIN:**
  - MEM_RDEN1=0; the last word is captured.
  - At the end of the cycle: set tag[fill_idx]=fill_tag, and set valid[fill_idx]=1 unless flush_pend; go to IDLE.
- **Outside FILL:** MEM_RDEN1=0 and MEM_ADDR1 holds its last value (0 after reset).
- **During FILL/DRAIN:** READY=0 regardless of PC. PC and PC_VALID changes are ignored; the fill always completes for the latched line. Back in IDLE, lookup uses the then-current PC.
- **FLUSH:**
  - Clears all valid bits at the end of the cycle.
  - If asserted in FILL or DRAIN, it also sets flush_pend so the in-flight line is not validated.
  - flush_pend clears on entering IDLE.
- **Invalidation:** a line is only ever invalidated by FLUSH or RST. A fill overwrites the line's tag and data.

## Timing
- **Reset values** (end of the RST cycle): state=IDLE, all valid=0, ic=cc=0, cap_v=0, flush_pend=0, MEM_RDEN1=0, MEM_ADDR1=0, READY=0, IR=0. Tags and data are don't-care.
- **Reset mid-fill:** the fill is aborted. MEM_RDEN1=0 in the next cycle, the partial line stays invalid, and the MEM_DOUT1 returned after reset is not captured.
- **Miss timeline:**
  - Miss seen in IDLE at t0.
  - Reads issued t1..tLW (LW = LINE_WORDS), word i at t(i+1).
  - Word i captured at the end of t(i+2).
  - DRAIN at t(LW+1).
  - Hit at t(LW+2).
  - Miss penalty is LW+2 cycles (6 at defaults).
- **Throughput:** a hit costs 0 extra cycles, giving back-to-back hits every cycle.
- **No double-issue:** the block never issues a read for a line while that line is in DRAIN.

## Test plan
- **Cold miss:** RST, then PC=0x10, PC_VALID=1 held. Required:
  - STALL=1 at t0..t5.
  - MEM_RDEN1=1 at t1..t4 with MEM_ADDR1=4,5,6,7.
  - READY=1 at t6 with IR=mem[4].
- **Spatial hits:** after the cold miss, PC=0x14, 0x18, 0x1C on consecutive cycles. Required: READY=1 every cycle, IR=mem[5], mem[6], mem[7], MEM_RDEN1 stays 0.
- **Conflict eviction:** PC=0x110 (index 1, tag 1) after line 0x10 is filled. Required:
  - Fill with MEM_ADDR1=0x44..0x47, then hit.
  - PC=0x10 then misses again and refills addresses 4..7.
- **PC change mid-fill:** PC=0x10 misses; at t2 PC changes to 0x40. Required: the fill of 4..7 completes, valid[1] is set, and 0x40 starts its own miss at t6 (MEM_ADDR1=0x10 at t7).
- **Reset mid-fill:** RST=1 at t2. Required: MEM_RDEN1=0 at t3, then PC=0x10 misses again with a full 6-cycle penalty.
- **Flush:**
  - FLUSH for one cycle after line 0x10 is valid: the next access to 0x10 misses.
  - FLUSH at t3 of a fill: the fill finishes but valid stays 0, so the access at t6 misses again.
